// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between N requesters and the hold arbiter.
// master: requester side (drives req); slave: arbiter side (drives grant).
interface rr_hold_arbiter_if #(
    parameter int N = 4
) ();
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_valid;
    logic            preempt;

    modport master (
        output req,
        input  grant,
        input  grant_id,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output grant_id,
        output grant_valid,
        output preempt
    );
endinterface

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with bounded grant hold and forced rotation.
// Ports: clk, rst (async, active-high), bus (slave: req in; grant,
// grant_id, grant_valid, preempt out, all registered).
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst,
    rr_hold_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] hold_cnt;
    logic [ID_W-1:0] last_id;
    logic [N-1:0]    grant_q;
    logic [ID_W-1:0] grant_id_q;
    logic            grant_valid_q;
    logic            preempt_q;

    logic [ID_W-1:0] pick_id;
    logic            pick_hit;
    logic [N-1:0]    pick_oh;
    logic [ID_W-1:0] idx;
    logic            own_req;
    logic            others;
    logic            hold_full;

    // Scan last_id+1 .. last_id+N so last_id itself has lowest priority.
    // In GRANT last_id is the owner, so any other pending request beats it.
    always_comb begin
        pick_id  = '0;
        pick_hit = 1'b0;
        idx      = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ID_W'((int'(last_id) + i) % N);
            if (!pick_hit && bus.req[idx]) begin
                pick_hit = 1'b1;
                pick_id  = idx;
            end
        end
    end

    assign pick_oh   = {{(N-1){1'b0}}, 1'b1} << pick_id;
    assign own_req   = |(bus.req & grant_q);
    assign others    = |(bus.req & ~grant_q);
    assign hold_full = (hold_cnt == CNT_W'(MAX_HOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            last_id       <= ID_W'(N - 1);
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            preempt_q     <= 1'b0;
        end else begin
            preempt_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_hit) begin
                        grant_q       <= pick_oh;
                        grant_id_q    <= pick_id;
                        grant_valid_q <= 1'b1;
                        hold_cnt      <= CNT_W'(1);
                        last_id       <= pick_id;
                        state         <= GRANT;
                    end
                end
                GRANT: begin
                    unique case (1'b1)
                        (!own_req && others),
                        (own_req && hold_full && others): begin
                            grant_q    <= pick_oh;
                            grant_id_q <= pick_id;
                            hold_cnt   <= CNT_W'(1);
                            last_id    <= pick_id;
                            preempt_q  <= own_req;
                        end
                        (!own_req && !others): begin
                            grant_q       <= '0;
                            grant_valid_q <= 1'b0;
                            hold_cnt      <= '0;
                            state         <= IDLE;
                        end
                        default: begin
                            if (!hold_full)
                                hold_cnt <= hold_cnt + 1'b1;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.preempt     = preempt_q;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (N=4, MAX_HOLD=4).
// Vector table plus hand sequences for rotation, fairness and reset.
module tb_rr_hold_arbiter;
    localparam int N = 4;
    localparam int MH = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rr_hold_arbiter_if #(.N(N)) bus ();

    rr_hold_arbiter #(
        .N(N),
        .MAX_HOLD(MH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] gid;
        logic       gv;
        logic       pre;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [3:0] rq,
                       input logic [3:0] g, input logic [1:0] id,
                       input logic v, input logic p);
        vec_t e;
        e.do_rst = r;
        e.req    = rq;
        e.grant  = g;
        e.gid    = id;
        e.gv     = v;
        e.pre    = p;
        tbl.push_back(e);
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b1;
        #1;
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_gid", 32'(bus.grant_id), 0);
        check("rst_gv", 32'(bus.grant_valid), 0);
        check("rst_pre", 32'(bus.preempt), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_inv(input string nm);
        check({nm, "_onehot"}, 32'($onehot0(bus.grant)), 1);
        check({nm, "_gv"}, 32'(bus.grant_valid), 32'(|bus.grant));
        if (bus.grant_valid)
            check({nm, "_gid"}, 32'(bus.grant[bus.grant_id]), 1);
    endtask

    int wait_cnt[N];
    int max_wait;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        bus.req = '0;

        // single requester, held, then released
        add(1, 4'b0001, 4'b0001, 0, 1, 0);
        for (int i = 0; i < 10; i++)
            add(0, 4'b0001, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 0, 0);
        // preemption ping-pong between 0 and 2
        add(1, 4'b0101, 4'b0001, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            add(0, 4'b0101, 4'b0001, 0, 1, 0);
        add(0, 4'b0101, 4'b0100, 2, 1, 1);
        for (int i = 0; i < 3; i++)
            add(0, 4'b0101, 4'b0100, 2, 1, 0);
        add(0, 4'b0101, 4'b0001, 0, 1, 1);
        add(0, 4'b0101, 4'b0001, 0, 1, 0);
        // release handover without a bubble
        add(0, 4'b0110, 4'b0010, 1, 1, 0);
        add(0, 4'b0110, 4'b0010, 1, 1, 0);
        add(0, 4'b0100, 4'b0100, 2, 1, 0);
        add(0, 4'b1100, 4'b0100, 2, 1, 0);
        add(0, 4'b1000, 4'b1000, 3, 1, 0);
        // idle keeps grant_id; wrap-around from last_id=3
        add(0, 4'b0000, 4'b0000, 3, 0, 0);
        add(0, 4'b1001, 4'b0001, 0, 1, 0);
        add(0, 4'b1000, 4'b1000, 3, 1, 0);
        add(0, 4'b0000, 4'b0000, 3, 0, 0);

        #2;
        foreach (tbl[k]) begin
            if (tbl[k].do_rst)
                do_reset();
            bus.req = tbl[k].req;
            step();
            check($sformatf("v%0d_grant", k), 32'(bus.grant),
                  32'(tbl[k].grant));
            check($sformatf("v%0d_gid", k), 32'(bus.grant_id),
                  32'(tbl[k].gid));
            check($sformatf("v%0d_gv", k), 32'(bus.grant_valid),
                  32'(tbl[k].gv));
            check($sformatf("v%0d_pre", k), 32'(bus.preempt),
                  32'(tbl[k].pre));
        end

        // all requesting: 4-cycle slots rotating 0,1,2,3,0
        do_reset();
        foreach (wait_cnt[i])
            wait_cnt[i] = 0;
        max_wait = 0;
        for (int c = 0; c < 20; c++) begin
            logic [3:0] one;
            bus.req = 4'b1111;
            step();
            one = 4'b0001;
            check($sformatf("all%0d_grant", c), 32'(bus.grant),
                  32'(one << ((c / MH) % N)));
            check($sformatf("all%0d_pre", c), 32'(bus.preempt),
                  32'((c % MH == 0) && (c > 0)));
            check_inv($sformatf("all%0d", c));
            for (int i = 0; i < N; i++) begin
                if (bus.grant[i])
                    wait_cnt[i] = 0;
                else
                    wait_cnt[i]++;
                if (wait_cnt[i] > max_wait)
                    max_wait = wait_cnt[i];
            end
        end
        check("fairness_le12", 32'(max_wait <= (N - 1) * MH), 1);

        // async reset in mid-cycle while granted to 2
        do_reset();
        bus.req = 4'b0100;
        step();
        check("mr_grant0", 32'(bus.grant), 32'(4'b0100));
        #3;
        rst = 1'b1;
        #1;
        check("mr_async_grant", 32'(bus.grant), 0);
        check("mr_async_gv", 32'(bus.grant_valid), 0);
        bus.req = 4'b1100;
        @(negedge clk);
        rst = 1'b0;
        step();
        check("mr_after_grant", 32'(bus.grant), 32'(4'b0100));
        check("mr_after_gid", 32'(bus.grant_id), 2);
        check_inv("mr_after");
        step();
        check("mr_hold_grant", 32'(bus.grant), 32'(4'b0100));
        check("mr_hold_pre", 32'(bus.preempt), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
